// File: rtl/regfile_sb_if.sv
// Interface for regfile_sb: read ports, write port, scoreboard reserve and busy count.
// The master side drives indices, write and reserve strobes; the slave side is the file.
interface regfile_sb_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_sel;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_sel;
    logic [XLEN/8-1:0]   wr_be;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_sel;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_be, wr_data, rsv_en, rsv_sel,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_be, wr_data, rsv_en, rsv_sel,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with byte-enabled writes, N combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard with population count.
module regfile_sb #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic wr_act, rsv_act, same_sel, cnt_inc, cnt_dec;

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_v,
                                              input logic [XLEN-1:0] new_v,
                                              input logic [NB-1:0]   be);
        logic [XLEN-1:0] res;
        res = old_v;
        for (int b = 0; b < int'(NB); b++) begin
            if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Index 0 is hardwired: its writes and reserves never take effect.
    assign wr_act   = bus.wr_en && (bus.wr_sel != '0);
    assign rsv_act  = bus.rsv_en && (bus.rsv_sel != '0);
    assign same_sel = bus.rsv_sel == bus.wr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
        end else if (wr_act) begin
            regs_q[bus.wr_sel] <= merge(regs_q[bus.wr_sel], bus.wr_data, bus.wr_be);
        end
    end

    // Release first, then reserve, so a same-edge reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_act)  busy_d[bus.wr_sel]  = 1'b0;
        if (rsv_act) busy_d[bus.rsv_sel] = 1'b1;
    end

    assign cnt_inc = rsv_act && !busy_q[bus.rsv_sel];
    assign cnt_dec = wr_act && busy_q[bus.wr_sel] && !(rsv_act && same_sel);
    assign cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.busy_cnt = cnt_q;

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [AW-1:0] sel;
        logic          hit;
        logic          rsv_here;

        assign sel      = bus.rd_sel[k*AW +: AW];
        // Bypass is suppressed during reset so outputs read 0 while rst_n is low.
        assign hit      = BYPASS && rst_n && wr_act && (bus.wr_sel == sel);
        assign rsv_here = rsv_act && (bus.rsv_sel == sel);

        assign bus.rd_data[k*XLEN +: XLEN] =
            hit ? merge(regs_q[sel], bus.wr_data, bus.wr_be) : regs_q[sel];
        assign bus.rd_busy[k] = busy_q[sel] && !(hit && !rsv_here);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_sb;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NRD*AW-1:0] rd_sel = '0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_sel = '0;
    logic [7:0]        wr_be = '0;
    logic [XLEN-1:0]   wr_data = '0;
    logic              rsv_en = 1'b0;
    logic [AW-1:0]     rsv_sel = '0;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus1 ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus0 ();

    assign bus1.rd_sel  = rd_sel;
    assign bus1.wr_en   = wr_en;
    assign bus1.wr_sel  = wr_sel;
    assign bus1.wr_be   = wr_be;
    assign bus1.wr_data = wr_data;
    assign bus1.rsv_en  = rsv_en;
    assign bus1.rsv_sel = rsv_sel;
    assign bus0.rd_sel  = rd_sel;
    assign bus0.wr_en   = wr_en;
    assign bus0.wr_sel  = wr_sel;
    assign bus0.wr_be   = wr_be;
    assign bus0.wr_data = wr_data;
    assign bus0.rsv_en  = rsv_en;
    assign bus0.rsv_sel = rsv_sel;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        wr_be  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic sel2(input logic [AW-1:0] a, input logic [AW-1:0] b);
        rd_sel = {b, a};
        #1;
    endtask

    task automatic write(input logic [AW-1:0] s, input logic [63:0] d, input logic [7:0] be);
        wr_en = 1'b1; wr_sel = s; wr_data = d; wr_be = be;
    endtask

    task automatic reserve(input logic [AW-1:0] s);
        rsv_en = 1'b1; rsv_sel = s;
    endtask

    initial begin
        // Reset state across every index
        #3;
        for (int i = 0; i < int'(NREGS); i++) begin
            sel2(AW'(i), AW'(NREGS - 1 - i));
            check("rst_rd0", bus1.rd_data[63:0], 64'h0);
            check("rst_rd1", bus1.rd_data[127:64], 64'h0);
            check("rst_busy", {62'h0, bus1.rd_busy}, 64'h0);
        end
        check("rst_cnt", {59'h0, bus1.busy_cnt}, 64'h0);
        write(5'd5, 64'h1234, 8'hFF);
        sel2(5'd5, 5'd0);
        check("rst_nobypass", bus1.rd_data[63:0], 64'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        // x0 is hardwired to zero
        write(5'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        reserve(5'd0);
        tick();
        idle();
        sel2(5'd0, 5'd0);
        check("x0_data", bus1.rd_data[63:0], 64'h0);
        check("x0_busy", {62'h0, bus1.rd_busy}, 64'h0);
        check("x0_cnt", {59'h0, bus1.busy_cnt}, 64'h0);

        // Byte-enabled partial write
        write(5'd5, 64'h11223344_55667788, 8'hFF);
        tick();
        write(5'd5, 64'hAAAAAAAA_AAAAAAAA, 8'h0F);
        tick();
        idle();
        sel2(5'd5, 5'd5);
        check("x5_merge", bus1.rd_data[63:0], 64'h11223344_AAAAAAAA);
        check("x5_merge_p1", bus0.rd_data[127:64], 64'h11223344_AAAAAAAA);

        // Same-cycle write visibility: bypass vs stored value
        write(5'd7, 64'h42, 8'hFF);
        sel2(5'd7, 5'd5);
        check("byp_on", bus1.rd_data[63:0], 64'h42);
        check("byp_off", bus0.rd_data[63:0], 64'h0);
        tick();
        write(5'd5, 64'h0000_0000_0000_00FF, 8'h01);
        sel2(5'd7, 5'd5);
        check("byp_off_after", bus0.rd_data[63:0], 64'h42);
        check("byp_partial", bus1.rd_data[127:64], 64'h11223344_AAAAAAFF);
        check("byp_partial_off", bus0.rd_data[127:64], 64'h11223344_AAAAAAAA);
        tick();
        idle();

        // Scoreboard reserve/release
        reserve(5'd3);
        tick();
        reserve(5'd4);
        tick();
        idle();
        sel2(5'd3, 5'd4);
        check("cnt_2", {59'h0, bus1.busy_cnt}, 64'd2);
        check("busy_34", {62'h0, bus1.rd_busy}, 64'b11);
        write(5'd3, 64'h33, 8'hFF);
        #1;
        check("busy_byp_on", {62'h0, bus1.rd_busy}, 64'b10);
        check("busy_byp_off", {62'h0, bus0.rd_busy}, 64'b11);
        tick();
        idle();
        #1;
        check("cnt_rel", {59'h0, bus1.busy_cnt}, 64'd1);
        check("busy_rel", {62'h0, bus0.rd_busy}, 64'b10);
        check("x3_data", bus0.rd_data[63:0], 64'h33);
        write(5'd7, 64'h77, 8'hFF);
        tick();
        idle();
        sel2(5'd7, 5'd4);
        check("cnt_nonbusy_wr", {59'h0, bus1.busy_cnt}, 64'd1);
        check("busy_x7", {62'h0, bus1.rd_busy}, 64'b10);

        // Same-edge reserve and write on a busy register
        reserve(5'd9);
        tick();
        check("cnt_x9", {59'h0, bus1.busy_cnt}, 64'd2);
        reserve(5'd9);
        write(5'd9, 64'h99, 8'hFF);
        sel2(5'd9, 5'd9);
        check("busy_x9_rsvwr", {62'h0, bus1.rd_busy}, 64'b11);
        tick();
        idle();
        #1;
        check("x9_data", bus0.rd_data[63:0], 64'h99);
        check("x9_busy", {62'h0, bus0.rd_busy}, 64'b11);
        check("cnt_x9_same", {59'h0, bus1.busy_cnt}, 64'd2);

        // Re-reserve busy register, then release with no byte enables
        reserve(5'd4);
        tick();
        idle();
        check("cnt_rersv", {59'h0, bus1.busy_cnt}, 64'd2);
        write(5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        tick();
        idle();
        sel2(5'd4, 5'd9);
        check("x4_be0_data", bus1.rd_data[63:0], 64'h0);
        check("x4_be0_busy", {62'h0, bus1.rd_busy}, 64'b10);
        check("cnt_be0", {59'h0, bus1.busy_cnt}, 64'd1);

        // Asynchronous reset mid-cycle
        reserve(5'd10);
        tick();
        idle();
        write(5'd11, 64'h5, 8'hFF);
        tick();
        idle();
        sel2(5'd11, 5'd10);
        check("pre_rst_x11", bus1.rd_data[63:0], 64'h5);
        check("pre_rst_cnt", {59'h0, bus1.busy_cnt}, 64'd2);
        write(5'd11, 64'h7, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x11", bus1.rd_data[63:0], 64'h0);
        check("mid_rst_busy", {62'h0, bus1.rd_busy}, 64'h0);
        check("mid_rst_cnt", {59'h0, bus1.busy_cnt}, 64'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        sel2(5'd5, 5'd9);
        check("post_rst_x5", bus1.rd_data[63:0], 64'h0);
        check("post_rst_x9", bus0.rd_data[127:64], 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined core, successor to the fixed 64x32 file.
- Adds N read ports, an explicit write enable and per-byte write enables.
- Adds optional write-to-read bypass and a per-register busy scoreboard that issue logic reserves and writeback clears.
- Sits between decode/issue (read, reserve) and writeback (write, release).

Parameters:
XLEN, 64, data width in bits; must be a multiple of 8.
NREGS, 32, number of architectural registers; power of two, at least 2.
AW, $clog2(NREGS), register index width; derived, not overridden.
NRD, 2, number of read ports.
BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = read returns the stored value.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_sel  in  NRD*AW  read indices, port k at bits [k*AW +: AW].
rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
rd_busy  out  NRD  scoreboard busy bit of each read index.
wr_en  in  1  write strobe.
wr_sel  in  AW  write index.
wr_be  in  XLEN/8  byte enables for the write.
wr_data  in  XLEN  write data.
rsv_en  in  1  reserve strobe: marks rsv_sel pending.
rsv_sel  in  AW  register to reserve.
busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst_n low, async):
  - all registers cleared to 0; all busy bits cleared; busy_cnt = 0.
  - rd_data reads 0 and rd_busy reads 0 while reset is held.
- Register 0:
  - always reads 0 and is never busy.
  - writes and reserves to index 0 are ignored and do not change busy_cnt.
- Reads: combinational, 0-cycle latency; every read port is independent.
- Write: on a rising edge with wr_en=1 and wr_sel!=0:
  - byte b of reg[wr_sel] takes wr_data byte b when wr_be[b]=1; other bytes are kept.
  - all-zero wr_data is a normal write.
  - wr_be all zero updates no data but still releases busy.
- Bypass (BYPASS=1):
  - if wr_en=1, wr_sel!=0 and rd_sel[k]==wr_sel, rd_data[k] = stored value merged with wr_data per wr_be (write-first).
  - BYPASS=0: the stored value is returned until the edge.
- Scoreboard:
  - busy[r] is set on an edge with rsv_en=1 and rsv_sel=r.
  - busy[r] is cleared on an edge with wr_en=1 and wr_sel=r.
  - reserve and write to the same register on the same edge: busy stays/becomes 1 (the new producer wins); the data write still occurs.
  - reserving an already-busy register: stays busy, busy_cnt unchanged.
  - a write to a non-busy register: data written, busy stays 0.
- rd_busy[k]:
  - equals busy[rd_sel[k]] as registered, i.e. before the current edge.
  - BYPASS=1 only: reads 0 when the same-cycle write targets that index and rsv_en does not target it.
- busy_cnt:
  - registered population count of busy bits.
  - updates on the same edge as the busy bits; net change is -1, 0 or +1 per cycle.
  - maximum NREGS-1.
- Reset asserted mid-operation: contents and scoreboard clear immediately; pending reservations are lost.

Test Plan:
- Reset then read all indices -> rd_data=0, rd_busy=0, busy_cnt=0; write 0xDEADBEEF_CAFEF00D to x0 -> x0 still reads 0.
- Write x5=0x1122334455667788 with wr_be=0xFF, then write x5 data 0xAAAA_AAAA_AAAA_AAAA with wr_be=0x0F -> x5 reads 0x11223344AAAAAAAA.
- BYPASS=1: read x7 on port 0 while writing x7=0x42 in the same cycle -> rd_data[0]=0x42 before the edge. BYPASS=0: same stimulus -> old value until the edge.
- Reserve x3, x4 on consecutive cycles -> busy_cnt=2, rd_busy set for x3/x4. Write x3 -> busy_cnt=1. Write x7 (non-busy) -> busy_cnt unchanged.
- Same edge rsv_sel=x9 and wr_sel=x9 with x9 busy -> data updated, x9 still busy, busy_cnt unchanged.
- Reserve x10, write x11=5, assert rst_n low mid-cycle (async) -> outputs 0 and busy_cnt=0 before the next clock edge.
